// File: rtl/spart.sv
// rtl/spart.sv - 8N1 serial port with bus-programmable 16x oversampled baud divisor
module spart (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] DB_RESET = 16'd163;

  // rst_n is active-high despite its name
  logic        rst;
  logic        bus_wr;
  logic        bus_rd_buf;
  logic        bus_rd_stat;
  logic [15:0] db;
  logic [15:0] baud_cnt;
  logic        tick;

  state_t      tx_state;
  logic [7:0]  tx_shift;
  logic [3:0]  tx_tick_cnt;
  logic [2:0]  tx_bit_cnt;

  state_t      rx_state;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_buf;
  logic [3:0]  rx_tick_cnt;
  logic [2:0]  rx_bit_cnt;

  assign rst         = rst_n;
  assign bus_wr      = iocs & ~iorw;
  assign bus_rd_buf  = iocs & iorw & (ioaddr == 2'b00);
  assign bus_rd_stat = iocs & iorw & (ioaddr == 2'b01);

  // Reads drive the bus combinationally; everything else leaves it floating
  assign databus = bus_rd_buf  ? rx_buf :
                   bus_rd_stat ? {6'b0, tbr, rda} : 8'bz;

  // Tick fires when the down-counter hits zero; a divisor of 0 behaves as 1
  assign tick = (baud_cnt == 16'd0);

  // Baud down-counter, reloads from the current divisor only on wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= 16'd0;
    end else if (tick) begin
      baud_cnt <= (db == 16'd0) ? 16'd0 : db - 16'd1;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // Write-only divisor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= DB_RESET;
    end else if (bus_wr && ioaddr == 2'b10) begin
      db[7:0] <= databus;
    end else if (bus_wr && ioaddr == 2'b11) begin
      db[15:8] <= databus;
    end
  end

  // Transmit FSM: IDLE with tbr=0 means a byte is loaded and waits for a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= IDLE;
      tx_shift    <= 8'd0;
      tx_tick_cnt <= 4'd0;
      tx_bit_cnt  <= 3'd0;
      tbr         <= 1'b1;
      txd         <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tbr && bus_wr && ioaddr == 2'b00) begin
            tx_shift <= databus;
            tbr      <= 1'b0;
          end else if (!tbr && tick) begin
            tx_state    <= START;
            txd         <= 1'b0;
            tx_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
              tx_state   <= DATA;
              txd        <= tx_shift[0];
              tx_bit_cnt <= 3'd0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
              if (tx_bit_cnt == 3'd7) begin
                tx_state <= STOP;
                txd      <= 1'b1;
              end else begin
                tx_shift   <= {1'b0, tx_shift[7:1]};
                txd        <= tx_shift[1];
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if (tx_tick_cnt == 4'd15) begin
              tx_state <= IDLE;
              tbr      <= 1'b1;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: start validated at its midpoint, then sample every 16 ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= IDLE;
      rx_shift    <= 8'd0;
      rx_buf      <= 8'd0;
      rx_tick_cnt <= 4'd0;
      rx_bit_cnt  <= 3'd0;
      rda         <= 1'b0;
    end else begin
      // A buffer read clears rda; a byte completing this cycle overrides below
      if (bus_rd_buf) begin
        rda <= 1'b0;
      end
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state    <= START;
            rx_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd7) begin
              rx_tick_cnt <= 4'd0;
              rx_bit_cnt  <= 3'd0;
              rx_state    <= rx_sync ? IDLE : DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              rx_shift   <= {rx_sync, rx_shift[7:1]};
              rx_bit_cnt <= rx_bit_cnt + 3'd1;
              if (rx_bit_cnt == 3'd7) begin
                rx_state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
            if (rx_tick_cnt == 4'd15) begin
              rx_state <= IDLE;
              if (rx_sync) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
              end
            end
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart.sv
// tb/tb_spart.sv - two cross-wired spart instances with scoreboard and mailbox model
module tb_spart;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  // Instance A (transmitter side)
  logic       cs_a, rw_a, drv_a;
  logic [1:0] addr_a;
  logic [7:0] wd_a;
  wire  [7:0] bus_a;
  logic       rda_a, tbr_a, txd_a, rxd_a;

  // Instance B (receiver side), shared by stimulus and monitor
  logic       stim_cs_b, stim_rw_b, stim_drv_b, mon_cs_b, mon_en;
  logic [1:0] stim_addr_b;
  logic [7:0] stim_wd_b;
  logic       cs_b, rw_b;
  logic [1:0] addr_b;
  wire  [7:0] bus_b;
  logic       rda_b, tbr_b, txd_b, rxd_b;

  logic       use_tb_rx, tb_rx;

  // Expected bytes; the receive buffer is a mailbox holding only the latest
  logic [7:0] exp_q[$];

  assign bus_a  = drv_a ? wd_a : 8'bz;
  assign cs_b   = stim_cs_b | mon_cs_b;
  assign rw_b   = mon_cs_b ? 1'b1 : stim_rw_b;
  assign addr_b = mon_cs_b ? 2'b00 : stim_addr_b;
  assign bus_b  = stim_drv_b ? stim_wd_b : 8'bz;
  assign rxd_b  = use_tb_rx ? tb_rx : txd_a;
  assign rxd_a  = txd_b;

  spart u_a (.clk(clk), .rst_n(rst), .iocs(cs_a), .iorw(rw_a), .ioaddr(addr_a),
             .databus(bus_a), .rda(rda_a), .tbr(tbr_a), .txd(txd_a), .rxd(rxd_a));
  spart u_b (.clk(clk), .rst_n(rst), .iocs(cs_b), .iorw(rw_b), .ioaddr(addr_b),
             .databus(bus_b), .rda(rda_b), .tbr(tbr_b), .txd(txd_b), .rxd(rxd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_a = 1'b1; rw_a = 1'b0; addr_a = a; wd_a = d; drv_a = 1'b1;
    @(negedge clk);
    cs_a = 1'b0; drv_a = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    stim_cs_b = 1'b1; stim_rw_b = 1'b0; stim_addr_b = a; stim_wd_b = d; stim_drv_b = 1'b1;
    @(negedge clk);
    stim_cs_b = 1'b0; stim_drv_b = 1'b0;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs_a = 1'b1; rw_a = 1'b1; addr_a = a;
    #1 d = bus_a;
    @(negedge clk);
    cs_a = 1'b0; rw_a = 1'b0;
  endtask

  task automatic set_db(input logic [15:0] d);
    wr_a(2'b10, d[7:0]);
    wr_a(2'b11, d[15:8]);
    wr_b(2'b10, d[7:0]);
    wr_b(2'b11, d[15:8]);
    repeat (400) @(negedge clk);
  endtask

  // Send via A and time the frame: expect 160..161 baud periods plus slack
  task automatic tx_frame(input logic [7:0] b, input int p, input bit dup, input string name);
    int n;
    wr_a(2'b00, b);
    exp_q.push_back(b);
    check({name, "_tbr_busy"}, tbr_a, 0);
    n = 1;
    if (dup) begin
      wr_a(2'b00, 8'h12);
      n += 1;
      check({name, "_dup_ignored_tbr"}, tbr_a, 0);
    end
    while (!tbr_a && n < 200 * p + 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!tbr_a || n < 160 * p - 2 || n > 161 * p + 3) begin
      fails++;
      $display("FAIL %s_frame_len: got %0d cycles expected %0d..%0d", name, n, 160 * p - 2, 161 * p + 3);
    end
  endtask

  task automatic wait_rx(input int lim, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rx_drained"}, exp_q.size(), 0);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop, input int p);
    @(negedge clk);
    tb_rx = 1'b0;
    repeat (16 * p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      repeat (16 * p) @(negedge clk);
    end
    tb_rx = stop;
    repeat (16 * p) @(negedge clk);
    tb_rx = 1'b1;
    repeat (32 * p) @(negedge clk);
  endtask

  // Monitor: whenever B presents data, read it and compare with the mailbox
  initial begin
    logic [7:0] got;
    logic [7:0] expv;
    mon_cs_b = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rda_b && !rst) begin
        mon_cs_b = 1'b1;
        #1 got = bus_b;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rx_unexpected: got byte %0h expected none", got);
        end else begin
          expv = exp_q[$];
          exp_q.delete();
          check("rx_data", got, expv);
        end
        @(negedge clk);
        mon_cs_b = 1'b0;
        #1 check("rda_clear_after_read", rda_b, 0);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [15:0] dbv;
    int p;
    tests = 0; fails = 0;
    cs_a = 0; rw_a = 0; addr_a = 0; wd_a = 0; drv_a = 0;
    stim_cs_b = 0; stim_rw_b = 0; stim_addr_b = 0; stim_wd_b = 0; stim_drv_b = 0;
    mon_en = 0; use_tb_rx = 0; tb_rx = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Reset state
    check("reset_txd", txd_a, 1);
    check("reset_tbr", tbr_a, 1);
    check("reset_rda", rda_b, 0);
    rd_a(2'b01, d);
    check("reset_status", d, 8'h02);

    // A write to status is ignored and the DUT must not fight the bus
    @(negedge clk);
    cs_a = 1; rw_a = 0; addr_a = 2'b01; wd_a = 8'h5A; drv_a = 1;
    #1 check("write_no_drive", bus_a, 8'h5A);
    @(negedge clk);
    cs_a = 0; drv_a = 0;
    check("status_write_ignored_tbr", tbr_a, 1);
    check("status_write_ignored_txd", txd_a, 1);
    mon_en = 1;

    // Default divisor loopback
    tx_frame(8'h45, 163, 0, "default_db");
    wait_rx(2000, "default_db");
    check("default_db_tbr_idle", tbr_a, 1);

    // Halved divisor
    set_db(16'd81);
    tx_frame(8'hA5, 81, 0, "db81");
    wait_rx(2000, "db81");

    // Write while busy is ignored
    set_db(16'd4);
    tx_frame(8'h6C, 4, 1, "busy_write");
    wait_rx(500, "busy_write");

    // Random bytes over random small divisors, including 0 and 1
    for (int k = 0; k < 8; k++) begin
      dbv = (k < 2) ? 16'(k) : 16'($urandom_range(0, 6));
      p = (dbv == 0) ? 1 : int'(dbv);
      set_db(dbv);
      tx_frame(8'($urandom), p, 0, "random");
      wait_rx(20 * p + 200, "random");
    end

    // Glitch rejection at divisor 4
    set_db(16'd4);
    use_tb_rx = 1;
    repeat (10) @(negedge clk);
    tb_rx = 0;
    repeat (3) @(negedge clk);
    tb_rx = 1;
    repeat (16 * 16 * 4) @(negedge clk);
    check("glitch_rda", rda_b, 0);

    // Framing error leaves rda and buffer untouched
    mon_en = 0;
    exp_q.push_back(8'h3C);
    send_serial(8'h3C, 1'b1, 4);
    check("good_frame_rda", rda_b, 1);
    send_serial(8'h99, 1'b0, 4);
    check("framing_error_rda", rda_b, 1);
    mon_en = 1;
    wait_rx(100, "framing_error");

    // Overrun: second byte overwrites, rda stays set
    mon_en = 0;
    exp_q.push_back(8'h11);
    send_serial(8'h11, 1'b1, 4);
    exp_q.push_back(8'hE2);
    send_serial(8'hE2, 1'b1, 4);
    check("overrun_rda", rda_b, 1);
    mon_en = 1;
    wait_rx(100, "overrun");
    use_tb_rx = 0;

    // Reset mid-transmit aborts both frames
    repeat (20) @(negedge clk);
    wr_a(2'b00, 8'h00);
    repeat (16 * 4 * 3) @(negedge clk);
    check("mid_tx_line_low", txd_a, 0);
    rst = 1;
    @(negedge clk);
    check("mid_tx_reset_txd", txd_a, 1);
    check("mid_tx_reset_tbr", tbr_a, 1);
    check("mid_tx_reset_rda", rda_b, 0);
    rst = 0;
    repeat (3000) @(negedge clk);
    check("after_reset_rda", rda_b, 0);
    check("after_reset_no_pending", exp_q.size(), 0);
    check("a_never_received", rda_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
